// File: rtl/ones_count_arbiter.sv
// Round-robin arbiter that shares one ones-counter datapath among N_REQ requesters.
// Sequences load/shift until the datapath reports done, then acks the owner with the count.
module ones_count_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic [CNT_W-1:0]       count_out,
  output logic                   busy,
  output logic                   load_A,
  output logic                   shift,
  output logic [WIDTH-1:0]       A_out,
  input  logic                   done_datapath,
  input  logic [CNT_W-1:0]       result
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StResp} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IdxW-1:0] winner;
  logic            found;

  // First requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % N_REQ;
      if (!found && req[idx[IdxW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          owner_d = winner;
          state_d = StLoad;
        end
      end
      StLoad:  state_d = StShift;
      StShift: begin
        if (done_datapath) begin
          count_d = result;
          state_d = StResp;
        end
      end
      StResp: begin
        if (owner_q == IdxW'(N_REQ - 1)) rr_ptr_d = '0;
        else                             rr_ptr_d = owner_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Outputs decode from registered state so reset clears them asynchronously.
  always_comb begin
    busy   = (state_q != StIdle);
    load_A = (state_q == StLoad);
    shift  = (state_q == StShift) && !done_datapath;
    grant  = '0;
    ack    = '0;
    A_out  = '0;
    if (busy) begin
      grant[owner_q] = 1'b1;
      A_out          = data[32'(owner_q)*WIDTH +: WIDTH];
    end
    if (state_q == StResp) ack[owner_q] = 1'b1;
  end

  assign count_out = count_q;

endmodule

// File: doc/ones_count_arbiter.md
# ones_count_arbiter

Controller that shares one ones-counter datapath (load/shift/done interface, result = number of 1s in the loaded word) between `N_REQ` independent requesters. It grants requesters round-robin, loads the granted word into the datapath, and sequences shifts until the datapath reports done. It then returns the count to the winner with a one-cycle acknowledge. It sits between the board-level request sources and a single datapath instance, replacing the single-user controller when several sources need bit counts.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, word width counted by the datapath
- `CNT_W`, 4, result width; must satisfy 2^CNT_W > WIDTH

Ports:
- `clock`  in  1  single system clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `req`  in  N_REQ  per-requester request level; held until matching `ack`
- `data`  in  N_REQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH]; stable while `req[i]` is high
- `grant`  out  N_REQ  one-hot, owner of the datapath for the current job
- `ack`  out  N_REQ  one-cycle pulse to the owner; `count_out` is valid in that cycle
- `count_out`  out  CNT_W  registered result for the acked requester
- `busy`  out  1  high in every state except IDLE
- `load_A`  out  1  datapath load strobe
- `shift`  out  1  datapath shift enable
- `A_out`  out  WIDTH  word driven to the datapath; equals the owner's `data` slice, 0 when idle
- `done_datapath`  in  1  datapath flag, high when its internal word register is zero
- `result`  in  CNT_W  datapath running count

## Operation
- States: IDLE, LOAD, SHIFT, RESP.
- IDLE
  - If `req` is nonzero, select the first set bit at or after `rr_ptr`, wrapping modulo N_REQ.
  - Register the winner index and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD
  - `load_A`=1 for exactly one cycle. Datapath captures `A_out` and clears its count.
  - Go to SHIFT.
- SHIFT
  - If `done_datapath`=0: `shift`=1, stay in SHIFT.
  - If `done_datapath`=1: `shift`=0, capture `result` into `count_out`, go to RESP.
- RESP
  - `ack[owner]`=1.
  - `rr_ptr` <= (owner+1) mod N_REQ.
  - Go to IDLE.
- `grant[owner]` is high from LOAD through RESP inclusive and 0 in IDLE.
- `load_A` and `shift` are never high in the same cycle.
- `count_out` holds its value until the next RESP.
- Requester dropping `req` mid-job: the job still completes and `ack` still pulses. The winner is not re-arbitrated.
- Requester keeping `req` high after its `ack`: treated as a new request. Round-robin prevents starvation of other requesters.
- Only requests present in the IDLE cycle are considered. New requests arriving during a job wait.
- Reset values: state IDLE, `rr_ptr`=0, `grant`=0, `ack`=0, `count_out`=0, `busy`=0, `load_A`=0, `shift`=0, `A_out`=0.

## Timing
- Let s = (index of highest set bit of the word)+1, or s=0 for an all-zero word.
- With the request sampled in IDLE at cycle 0:
  - LOAD at cycle 1.
  - SHIFT with `shift`=1 during cycles 2..s+1.
  - SHIFT with done at cycle s+2.
  - RESP / `ack` at cycle s+3.
- Next arbitration (IDLE) happens at cycle s+4.
- Worst case for WIDTH=8, word 8'h80 or 8'hFF: `ack` at cycle 11.
- Best case, word 0: `ack` at cycle 3.
- `done_datapath` is sampled only in SHIFT. Its value in the LOAD cycle is ignored (the datapath has not yet captured).
- Asserting `reset` in any state forces all outputs to reset values without waiting for a clock edge. The in-flight job is discarded and no `ack` is issued. Operation resumes from IDLE on the first edge after `reset` falls.

## Test plan
- Single requester: `req`=4'b0001, word 8'b01010101.
  - `grant`=0001 from cycle 1.
  - `load_A` at cycle 1, `shift` high 7 cycles.
  - `ack`=0001 at cycle 10 with `count_out`=4.
- Zero word: requester 2 with 8'h00 → no `shift` pulses, `ack[2]` at cycle 3, `count_out`=0.
- Full word: 8'hFF → `shift` high 8 cycles, `count_out`=8, `ack` at cycle 11.
- Round-robin: `req`=4'b1111 held continuously with distinct words → grants in order 0,1,2,3,0. Each `ack` goes to the matching bit with that word's count. `grant` is always one-hot.
- Simultaneous events: requester 1 raises `req` while requester 3 is in SHIFT. Requester 1 is not granted until the IDLE cycle after requester 3's `ack`. `load_A` and `shift` are never both high.
- Reset mid-operation: assert `reset` during SHIFT of requester 0.
  - All outputs 0 immediately; no `ack[0]`.
  - After release with `req`=4'b0011, the first grant goes to requester 0 (`rr_ptr`=0).
